// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: N x N output-stationary systolic matrix multiplier.
// Operand vectors (one column of A, one row of B) stream in over a valid/ready
// handshake. Each vector is skewed so that A[i][k] and B[k][j] meet in PE(i,j).
// A zero-injecting flush then completes the wavefront. All N*N accumulators
// are streamed out row-major over a valid/ready port.
// Optional build macro: SA_OUT_SAT_EN.
//   Defined:   out_data saturates to the signed OUT_W range.
//   Undefined: out_data is the low OUT_W bits of the accumulator.
module systolic_array_nxn #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int KW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_vec,
  input  logic [N*DW-1:0]   b_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              done
);

  localparam int NN        = N * N;
  localparam int IDX_W     = (NN > 1) ? $clog2(NN) : 1;
  localparam int FLUSH_CYC = 2 * N - 2;
  localparam int FL_W      = $clog2(2 * N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [KW-1:0]      k_len_reg, k_cnt_reg;
  logic [FL_W-1:0]    fl_cnt_reg;
  logic [IDX_W-1:0]   idx_reg, idx_inc;
  logic               out_valid_reg, out_last_reg, done_reg;
  logic [OUT_W-1:0]   out_data_reg;

  logic start_acc, in_acc, k_last, flush_step, fl_last, advance, out_acc, last_acc;

  logic signed [DW-1:0]    a_inj  [N];
  logic signed [DW-1:0]    b_inj  [N];
  logic signed [DW-1:0]    a_edge [N];
  logic signed [DW-1:0]    b_edge [N];
  logic signed [DW-1:0]    a_pe_reg [N][N];
  logic signed [DW-1:0]    b_pe_reg [N][N];
  logic signed [ACC_W-1:0] acc_reg  [NN];

  // Handshake and sequencing strobes
  assign start_acc  = (state_reg == IDLE) && start;
  assign in_acc     = (state_reg == LOAD) && in_valid;
  assign k_last     = in_acc && (k_cnt_reg == (k_len_reg - KW'(1)));
  assign flush_step = (state_reg == FLUSH);
  assign fl_last    = flush_step && (fl_cnt_reg == FL_W'(FLUSH_CYC - 1));
  assign advance    = in_acc || flush_step;
  assign out_acc    = out_valid_reg && out_ready;
  assign last_acc   = out_acc && out_last_reg;
  assign idx_inc    = idx_reg + 1'b1;

  assign busy      = (state_reg != IDLE);
  assign in_ready  = (state_reg == LOAD);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign done      = done_reg;

`ifdef SA_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  // Accumulator to output-width conversion (clamp or truncate)
  function automatic logic [OUT_W-1:0] conv(input logic signed [ACC_W-1:0] v);
`ifdef SA_OUT_SAT_EN
    if (v > SAT_MAX)      conv = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) conv = SAT_MIN[OUT_W-1:0];
    else                  conv = v[OUT_W-1:0];
`else
    conv = v[OUT_W-1:0];
`endif
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (k_len == '0) ? DRAIN : LOAD;
      LOAD:    if (k_last) state_next = (N == 1) ? DRAIN : FLUSH;
      FLUSH:   if (fl_last) state_next = DRAIN;
      DRAIN:   if (last_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Inner-dimension and flush counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_reg  <= '0;
      k_cnt_reg  <= '0;
      fl_cnt_reg <= '0;
    end else begin
      if (start_acc) begin
        k_len_reg <= k_len;
        k_cnt_reg <= '0;
      end else if (in_acc) begin
        k_cnt_reg <= k_cnt_reg + 1'b1;
      end
      fl_cnt_reg <= flush_step ? fl_cnt_reg + 1'b1 : '0;
    end
  end

  // Result stream: load element 0 on entering DRAIN, step on each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= last_acc;
      if (start_acc) begin
        idx_reg <= '0;
      end else if ((state_reg == DRAIN) && !out_valid_reg) begin
        idx_reg       <= '0;
        out_valid_reg <= 1'b1;
        out_last_reg  <= (NN == 1);
        out_data_reg  <= conv(acc_reg[0]);
      end else if (out_acc) begin
        if (out_last_reg) begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end else begin
          idx_reg      <= idx_inc;
          out_last_reg <= (idx_inc == IDX_W'(NN - 1));
          out_data_reg <= conv(acc_reg[idx_inc]);
        end
      end
    end
  end

  // Input skew: row i of A and column j of B are delayed by i / j steps
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    assign a_inj[gi] = flush_step ? '0 : $signed(a_vec[gi*DW +: DW]);
    assign b_inj[gi] = flush_step ? '0 : $signed(b_vec[gi*DW +: DW]);
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_inj[gi];
      assign b_edge[gi] = b_inj[gi];
    end else begin : g_delay
      logic signed [DW-1:0] a_sk_reg [gi];
      logic signed [DW-1:0] b_sk_reg [gi];
      // Shift chains advance only when the array steps
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int m = 0; m < gi; m++) begin
            a_sk_reg[m] <= '0;
            b_sk_reg[m] <= '0;
          end
        end else if (start_acc) begin
          for (int m = 0; m < gi; m++) begin
            a_sk_reg[m] <= '0;
            b_sk_reg[m] <= '0;
          end
        end else if (advance) begin
          a_sk_reg[0] <= a_inj[gi];
          b_sk_reg[0] <= b_inj[gi];
          for (int m = 1; m < gi; m++) begin
            a_sk_reg[m] <= a_sk_reg[m-1];
            b_sk_reg[m] <= b_sk_reg[m-1];
          end
        end
      end
      assign a_edge[gi] = a_sk_reg[gi-1];
      assign b_edge[gi] = b_sk_reg[gi-1];
    end
  end

  // Processing-element grid: a flows right, b flows down, acc stays put
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [DW-1:0]   a_in, b_in;
      logic signed [2*DW-1:0] prod;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_edge[gi];
      end else begin : g_a_pass
        assign a_in = a_pe_reg[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = b_edge[gj];
      end else begin : g_b_pass
        assign b_in = b_pe_reg[gi-1][gj];
      end

      assign prod = a_in * b_in;

      // MAC step; accumulator wraps modulo 2^ACC_W
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_pe_reg[gi][gj]  <= '0;
          b_pe_reg[gi][gj]  <= '0;
          acc_reg[gi*N+gj]  <= '0;
        end else if (start_acc) begin
          a_pe_reg[gi][gj]  <= '0;
          b_pe_reg[gi][gj]  <= '0;
          acc_reg[gi*N+gj]  <= '0;
        end else if (advance) begin
          a_pe_reg[gi][gj]  <= a_in;
          b_pe_reg[gi][gj]  <= b_in;
          acc_reg[gi*N+gj]  <= acc_reg[gi*N+gj] + ACC_W'(prod);
        end
      end
    end
  end

endmodule
